// File: rtl/remocon_tx.sv
// NEC-format IR transmitter: up/down button edges become 32-bit frames
// (addr, ~addr, cmd, ~cmd) on a 38 kHz carrier, paced by the 10 us tick strobe.
module remocon_tx #(
    parameter int         CARRIER_HALF = 1316,
    parameter logic [7:0] ADDR         = 8'h00,
    parameter logic [7:0] CMD_UP       = 8'h01,
    parameter logic [7:0] CMD_DOWN     = 8'h02,
    parameter int         T_LEAD_MARK  = 900,
    parameter int         T_LEAD_SPACE = 450,
    parameter int         T_BIT_MARK   = 56,
    parameter int         T_ZERO_SPACE = 56,
    parameter int         T_ONE_SPACE  = 169
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic up,
    input  logic down,
    output logic ir_out,
    output logic env,
    output logic busy,
    output logic done
);

    localparam int TW = 16;
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, ARM, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
    } state_t;

    state_t          state;
    logic [31:0]     sr;
    logic [4:0]      bcnt;
    logic [TW-1:0]   tcnt;
    logic [TW-1:0]   phase_len;
    logic            phase_end;
    logic [CW-1:0]   ccnt;
    logic            car_ph;
    logic            up_q, down_q, primed;
    logic            up_edge, down_edge;
    logic [7:0]      cmd;
    logic            mark_start;

    // primed stays low for the first clk after reset so a level already
    // high at release is absorbed into up_q/down_q instead of becoming an edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            primed <= 1'b0;
        end else begin
            up_q   <= up;
            down_q <= down;
            primed <= 1'b1;
        end
    end

    assign up_edge   = primed & up & ~up_q;
    assign down_edge = primed & down & ~down_q;
    assign cmd       = up_edge ? CMD_UP : CMD_DOWN;

    always_comb begin
        phase_len = TW'(1);
        case (state)
            LEAD_MARK:            phase_len = TW'(T_LEAD_MARK);
            LEAD_SPACE:           phase_len = TW'(T_LEAD_SPACE);
            BIT_MARK, STOP_MARK:  phase_len = TW'(T_BIT_MARK);
            BIT_SPACE:            phase_len = sr[0] ? TW'(T_ONE_SPACE) : TW'(T_ZERO_SPACE);
            default:              phase_len = TW'(1);
        endcase
    end

    // a phase of N ticks ends on the clk carrying its Nth tick
    assign phase_end = tick && (tcnt == phase_len - TW'(1));

    assign mark_start = (state == ARM && tick)
                     || (state == LEAD_SPACE && phase_end)
                     || (state == BIT_SPACE && phase_end);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sr    <= 32'd0;
            bcnt  <= 5'd0;
            tcnt  <= '0;
            env   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE || state == ARM)
                tcnt <= '0;
            else if (tick)
                tcnt <= phase_end ? '0 : tcnt + TW'(1);

            case (state)
                IDLE: begin
                    if (up_edge ^ down_edge) begin
                        sr    <= {~cmd, cmd, ~ADDR, ADDR};
                        bcnt  <= 5'd0;
                        busy  <= 1'b1;
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (tick) begin
                        env   <= 1'b1;
                        state <= LEAD_MARK;
                    end
                end
                LEAD_MARK: begin
                    if (phase_end) begin
                        env   <= 1'b0;
                        state <= LEAD_SPACE;
                    end
                end
                LEAD_SPACE: begin
                    if (phase_end) begin
                        env   <= 1'b1;
                        state <= BIT_MARK;
                    end
                end
                BIT_MARK: begin
                    if (phase_end) begin
                        env   <= 1'b0;
                        state <= BIT_SPACE;
                    end
                end
                BIT_SPACE: begin
                    if (phase_end) begin
                        env <= 1'b1;
                        if (bcnt == 5'd31) begin
                            state <= STOP_MARK;
                        end else begin
                            sr    <= sr >> 1;
                            bcnt  <= bcnt + 5'd1;
                            state <= BIT_MARK;
                        end
                    end
                end
                STOP_MARK: begin
                    if (phase_end) begin
                        env   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // carrier restarts high at every mark so each burst has the same shape
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ccnt   <= '0;
            car_ph <= 1'b0;
        end else if (mark_start) begin
            ccnt   <= '0;
            car_ph <= 1'b1;
        end else if (env) begin
            if (ccnt == CW'(CARRIER_HALF - 1)) begin
                ccnt   <= '0;
                car_ph <= ~car_ph;
            end else begin
                ccnt <= ccnt + CW'(1);
            end
        end
    end

    assign ir_out = env & car_ph;

endmodule

// File: tb/tb_remocon_tx.sv
// Directed bench for remocon_tx: frame timing/decoding, carrier shape,
// edge rules, busy drops and asynchronous reset.
module tb_remocon_tx;

    localparam int TP = 2;  // clks per tick
    localparam int CH = 5;  // shortened carrier half-period

    logic clk = 1'b0, rstn = 1'b0, tick = 1'b0, up = 1'b0, down = 1'b0;
    logic ir_out, env, busy, done;

    int npass = 0, ntot = 0, car_bad = 0, done_cnt = 0;

    remocon_tx #(.CARRIER_HALF(CH)) dut (
        .clk(clk), .rstn(rstn), .tick(tick), .up(up), .down(down),
        .ir_out(ir_out), .env(env), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick <= ~tick;
    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // clks env stays at lvl; also checks carrier pattern in marks and silence in spaces
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (env === lvl && n < 4000) begin
            if (lvl) begin
                if (ir_out !== (((n / CH) % 2) == 0)) car_bad++;
            end else if (ir_out !== 1'b0) car_bad++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic decode(input bit poke, output logic [31:0] data,
                          output int lm, output int ls, output int total);
        int n, m, s;
        data = 32'd0;
        car_bad = 0;
        n = 0;
        while (env !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        run_len(1'b1, lm);
        if (poke) down = 1'b1;
        run_len(1'b0, ls);
        if (poke) down = 1'b0;
        total = lm + ls;
        for (int i = 0; i < 32; i++) begin
            run_len(1'b1, m);
            run_len(1'b0, s);
            data[i] = (s > 56 * TP);
            total += m + s;
        end
        run_len(1'b1, m);
        total += m;
        lm = lm / TP;
        ls = ls / TP;
        total = total / TP;
    endtask

    initial begin
        logic [31:0] d;
        int lm, ls, tot, m;
        logic saw;

        repeat (3) @(negedge clk);
        chk("rst_ir_out", ir_out, 0);
        chk("rst_env", env, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // up edge lands on a tick clk: that tick must not start the leader
        while (tick !== 1'b1) @(negedge clk);
        up = 1'b1;
        @(negedge clk);
        chk("busy_arm", busy, 1);
        chk("env_arm", env, 0);
        @(negedge clk);
        chk("tick_same_clk", env, 0);
        @(negedge clk);
        chk("env_rise", env, 1);

        // up frame, with a down edge poked in while busy
        decode(1'b1, d, lm, ls, tot);
        chk("up_lead_mark", lm, 900);
        chk("up_lead_space", ls, 450);
        chk("up_data", d, 32'hFE01FF00);
        chk("up_total", tot, 6798);
        chk("up_done", done, 1);
        chk("up_busy_fall", busy, 0);
        chk("up_carrier", car_bad, 0);

        // up still held for two more frame lengths
        saw = 1'b0;
        repeat (27200) begin @(negedge clk); if (busy | env) saw = 1'b1; end
        chk("held_no_frame", saw, 0);
        chk("done_once_up", done_cnt, 1);

        // both edges in one clk
        up = 1'b0;
        repeat (4) @(negedge clk);
        up = 1'b1; down = 1'b1;
        saw = 1'b0;
        repeat (40) begin @(negedge clk); if (busy | env) saw = 1'b1; end
        chk("both_edges", saw, 0);
        up = 1'b0; down = 1'b0;
        repeat (4) @(negedge clk);

        // reset in the first bit space, down held through it
        down = 1'b1;
        m = 0;
        while (env !== 1'b1 && m < 100) begin m++; @(negedge clk); end
        run_len(1'b1, m);
        run_len(1'b0, m);
        run_len(1'b1, m);
        chk("pre_rst_busy", busy, 1);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_ir_out", ir_out, 0);
        chk("mid_rst_env", env, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        saw = 1'b0;
        repeat (500) begin @(negedge clk); if (busy | env) saw = 1'b1; end
        chk("no_frame_after_rst", saw, 0);
        chk("done_cnt_after_rst", done_cnt, 1);

        // down frame, then an up edge on the done clk
        down = 1'b0;
        repeat (3) @(negedge clk);
        down = 1'b1;
        decode(1'b0, d, lm, ls, tot);
        chk("down_data", d, 32'hFD02FF00);
        chk("down_total", tot, 6798);
        chk("down_done", done, 1);
        chk("down_carrier", car_bad, 0);
        up = 1'b1;
        @(negedge clk);
        chk("accept_after_done", busy, 1);
        chk("done_cnt_final", done_cnt, 2);
        chk("done_pulse_width", done, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
